uart_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_gen.sv | 47 ++++
 rtl/uart_transmitter.sv | 163 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: state encoding, data width and the
//               baud tick calculation used by both transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame sequencer states; PARITY is reachable only in the parity build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Clocks per serial bit, truncated toward zero.
  function automatic int baud_tick_calc(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period timer. Counts 0..BAUD_TICK-1 while enabled and
//               flags the last cycle of each bit period with bit_end_o.
//               clear_i restarts the period from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int BAUD_TICK = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o
);

  localparam int CNT_W = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_TICK - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : UART transmitter, 8N1 by default. Accepts a byte on a
//               valid/ready handshake and shifts it out LSB first with a
//               start and stop bit. tx is driven from a register.
//               Build option: define UART_TX_PARITY_EN to insert a parity
//               bit (even, or odd when PARITY_ODD = 1) after the last data bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int BAUD_TICK  = baud_tick_calc(CLK_FREQ, BAUD_RATE),
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic accept;
  logic bit_end;
  logic parity_bit;

  assign accept = tx_valid && (state_q == IDLE);

  uart_baud_gen #(
    .BAUD_TICK (BAUD_TICK)
  ) u_baud_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accept),
    .enable_i  (state_q != IDLE),
    .bit_end_o (bit_end)
  );

`ifdef UART_TX_PARITY_EN
  // Unshifted copy of the accepted byte, used only for the parity bit.
  logic [DATA_BITS-1:0] data_q, data_d;

  assign data_d     = accept ? tx_data : data_q;
  assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);

  // Latched-byte register for the parity calculation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end
`else
  logic unused_parity_odd;

  assign parity_bit        = 1'b1;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Frame sequencing: next state, shift register, bit counter and done pulse.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle follows the state being entered, so tx
  // changes on the same edge as the state and never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset returns the line to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Scoreboard bench for uart_transmitter at BAUD_TICK = 10.
//               Stimulus pushes expected frames; a negedge monitor rebuilds
//               frames from the line and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int TICK      = 10;
  localparam int PODD      = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * TICK;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;

  logic [10:0] exp_q[$];
  int          done_cyc[$];

  uart_transmitter #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .PARITY_ODD (PODD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        mon_active = 1'b0;
  int          off        = 0;
  logic [10:0] cap        = '1;
  logic [10:0] exp_f      = '1;
  logic        glitch     = 1'b0;
  logic        busy_err   = 1'b0;
  logic        prev_tx    = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      prev_tx    = 1'b1;
    end else begin
      if (tx_done) begin
        n_done++;
        if (!(mon_active && off == FRAME_CYC))
          check("unexpected_done", 32'd1, 32'd0);
      end
      if (mon_active && off == FRAME_CYC) begin
        check("done_at_frame_end", 32'(tx_done), 32'd1);
        check("frame_bits", 32'(cap), 32'(exp_f));
        check("bit_hold_busy", 32'({glitch, busy_err}), 32'd0);
        check("idle_after_frame", 32'({tx, tx_ready, tx_busy}), 32'(3'b110));
        done_cyc.push_back(cyc);
        mon_active = 1'b0;
      end
      if (!mon_active && prev_tx && !tx) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          exp_f = '1;
        end else begin
          exp_f = exp_q.pop_front();
        end
        mon_active = 1'b1;
        off        = 0;
        cap        = '1;
        glitch     = 1'b0;
        busy_err   = 1'b0;
      end
      if (mon_active && off < FRAME_CYC) begin
        if (off % TICK == 0) cap[4'(off / TICK)] = tx;
        else if (tx !== cap[4'(off / TICK)]) glitch = 1'b1;
        if (!tx_busy || tx_ready) busy_err = 1'b1;
        off++;
      end
      prev_tx = tx;
    end
  end

  // ---------------- stimulus ----------------
  // pe: hand-computed even parity of d. hold: keep tx_valid high afterwards.
  task automatic send(input logic [7:0] d, input logic pe, input logic hold);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("send_ready_timeout", 32'd1, 32'd0);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back({1'b1, pe ^ 1'(PODD), d, 1'b0});
`else
    exp_q.push_back({1'b1, 1'b1, d, 1'b0});
    if (pe) n = n + 0;
`endif
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'($urandom);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((exp_q.size() != 0 || mon_active) && n < 1000);
    if (n >= 1000) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #13;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single frame 0xA5
    done_cyc.delete();
    send(8'hA5, 1'b0, 1'b0);
    wait_idle();
    check("a5_done_count", 32'(done_cyc.size()), 32'd1);

    // Back-to-back 0x00 then 0xFF with tx_valid held
    done_cyc.delete();
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b0);
    wait_idle();
    check("b2b_done_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2)
      check("b2b_done_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(FRAME_CYC + 1));

    // tx_valid pulse during D4 must be ignored
    send(8'h3C, 1'b0, 1'b0);
    repeat (54) @(posedge clk);
    #1;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    check("busy_ready_low", 32'(tx_ready), 32'd0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("busy_still_busy", 32'({tx_ready, tx_busy}), 32'(2'b01));
    wait_idle();
    repeat (30) @(posedge clk);
    #1;

    // Reset at the 5th cycle of D3
    send(8'h5A, 1'b0, 1'b0);
    repeat (44) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'({tx, tx_ready, tx_busy, tx_done}), 32'(4'b1100));
    repeat (20) @(posedge clk);
    #1;

    // Clean frame after reset, then the parity vector
    send(8'h81, 1'b0, 1'b0);
    wait_idle();
    send(8'h07, 1'b1, 1'b0);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("total_done_pulses", 32'(n_done), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
